// File: rtl/calc1_pkg.sv
// Shared types for the CALC1 port request driver: command/response codes,
// driver FSM states and the queued request record.
package calc1_pkg;

    localparam int CMD_W        = 4;
    localparam int RSP_W        = 2;
    // Operand width carried in a queued request; the driver's DATA_W must match it.
    localparam int CALC1_DATA_W = 32;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } calc1_cmd_e;

    typedef enum logic [RSP_W-1:0] {
        RSP_NONE = 2'd0,
        RSP_OK   = 2'd1,
        RSP_ERR  = 2'd2,
        RSP_TMO  = 2'd3
    } calc1_rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP1,
        ST_OP2,
        ST_WAIT
    } drv_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]        cmd;
        logic [CALC1_DATA_W-1:0] op1;
        logic [CALC1_DATA_W-1:0] op2;
    } calc1_req_t;

endpackage

// File: rtl/calc1_req_fifo.sv
// Small synchronous FIFO of CALC1 request records; pointers wrap naturally
// because the depth is a power of two.
module calc1_req_fifo
    import calc1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     c_clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  calc1_req_t               push_data,
    input  logic                     pop,
    output calc1_req_t               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    calc1_req_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge c_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/calc1_req_driver.sv
// Per-port CALC1 request driver: queues requests, serialises them onto the
// two-cycle request bus, waits for the response and reports it (or a timeout).
module calc1_req_driver
    import calc1_pkg::*;
#(
    parameter int DATA_W     = CALC1_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 100
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    output logic [CMD_W-1:0]  reqcmd_out,
    output logic [DATA_W-1:0] reqdata_out,
    input  logic [RSP_W-1:0]  resp_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              rsp_valid,
    output logic [RSP_W-1:0]  rsp_code,
    output logic [CMD_W-1:0]  rsp_cmd,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              timeout_err,
    output logic              spurious_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT);

    drv_state_e       state;
    calc1_req_t       cur_req;
    calc1_req_t       fifo_in;
    calc1_req_t       fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_next;
    logic [TMO_W-1:0] wait_cnt;
    logic             resp_seen;
    logic             tmo_hit;
    logic             active_next;
    logic             busy_next;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_in   = '{cmd: req_cmd, op1: req_op1, op2: req_op2};
    assign resp_seen = (resp_in != RSP_NONE);
    assign tmo_hit   = (wait_cnt == TMO_W'(TIMEOUT - 1));

    // Holding the pop off while rsp_valid is high leaves the port one idle
    // cycle between a completion and the next command.
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !rsp_valid;

    calc1_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .c_clk     (c_clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // busy is registered, so it is built from where state and FIFO are heading.
    always_comb begin
        fifo_count_next = fifo_count;
        active_next     = 1'b0;
        if (fifo_push && !fifo_pop)      fifo_count_next = fifo_count + 1'b1;
        else if (!fifo_push && fifo_pop) fifo_count_next = fifo_count - 1'b1;
        case (state)
            ST_IDLE:        active_next = fifo_pop && (fifo_head.cmd != CMD_NOP);
            ST_OP1, ST_OP2: active_next = 1'b1;
            ST_WAIT:        active_next = !resp_seen && !tmo_hit;
            default:        active_next = 1'b0;
        endcase
        busy_next = active_next || (fifo_count_next != '0);
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cur_req      <= '0;
            wait_cnt     <= '0;
            reqcmd_out   <= '0;
            reqdata_out  <= '0;
            rsp_valid    <= 1'b0;
            rsp_code     <= RSP_NONE;
            rsp_cmd      <= '0;
            rsp_data     <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            busy      <= busy_next;
            if (resp_seen && (state != ST_WAIT)) spurious_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    reqcmd_out  <= '0;
                    reqdata_out <= '0;
                    if (fifo_pop && (fifo_head.cmd != CMD_NOP)) begin
                        cur_req <= fifo_head;
                        state   <= ST_OP1;
                    end
                end
                ST_OP1: begin
                    reqcmd_out  <= cur_req.cmd;
                    reqdata_out <= cur_req.op1;
                    state       <= ST_OP2;
                end
                ST_OP2: begin
                    reqcmd_out  <= '0;
                    reqdata_out <= cur_req.op2;
                    wait_cnt    <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    reqcmd_out  <= '0;
                    reqdata_out <= '0;
                    // A response arriving on the last allowed cycle beats the timeout.
                    if (resp_seen) begin
                        rsp_valid <= 1'b1;
                        rsp_code  <= resp_in;
                        rsp_cmd   <= cur_req.cmd;
                        rsp_data  <= data_in;
                        state     <= ST_IDLE;
                    end else if (tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_code    <= RSP_TMO;
                        rsp_cmd     <= cur_req.cmd;
                        rsp_data    <= '0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
